// File: rtl/viota_expander_if.sv
// Mask-beat / result-beat stream bundle for the viota expander.
// The master side feeds mask beats and sinks result beats; the slave side is the expander.
interface viota_expander_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
);
    logic                   mask_valid;
    logic                   mask_ready;
    logic [LANES-1:0]       mask;
    logic                   res_valid;
    logic                   res_ready;
    logic [LANES*CNT_W-1:0] res;
    logic [LANES-1:0]       res_en;
    logic                   res_last;

    modport master (
        output mask_valid, mask, res_ready,
        input  mask_ready, res_valid, res, res_en, res_last
    );

    modport slave (
        input  mask_valid, mask, res_ready,
        output mask_ready, res_valid, res, res_en, res_last
    );
endinterface

// File: rtl/viota_expander.sv
// Streaming mask-to-index expander: emits per-lane exclusive prefix counts of set mask
// bits, carrying the running count across beats of one operation.
//
// state | meaning
// IDLE  | waiting for start; total holds the previous result
// RUN   | accepting mask beats into the 1-deep result register
// DRAIN | last beat registered, waiting for its result handshake
// FIN   | one-cycle completion, done asserted
module viota_expander #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] vl,
    viota_expander_if.slave  bus,
    output logic [CNT_W-1:0] total,
    output logic             done,
    output logic             busy
);
    localparam int PW = $clog2(LANES) + 1;
    // One extra bit so elem_idx + LANES cannot wrap when vl is near its maximum.
    localparam int EW = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       vl_q;
    logic [CNT_W-1:0]       base;
    logic [EW-1:0]          elem_idx;
    logic                   accept;
    logic                   res_hs;
    logic                   beat_last;
    logic [LANES-1:0]       en_nx;
    logic [LANES-1:0]       m_nx;
    logic [LANES*CNT_W-1:0] res_nx;
    logic [PW-1:0]          pop;

    assign bus.mask_ready = (state == RUN) && (!bus.res_valid || bus.res_ready);
    assign accept         = bus.mask_valid && bus.mask_ready;
    assign res_hs         = bus.res_valid && bus.res_ready;
    assign beat_last      = (elem_idx + EW'(LANES)) >= EW'(vl_q);

    // Lane prefix sums; lanes at or beyond vl contribute nothing.
    always_comb begin
        en_nx  = '0;
        m_nx   = '0;
        res_nx = '0;
        pop    = '0;
        for (int j = 0; j < LANES; j++) begin
            en_nx[j]                 = (elem_idx + EW'(j)) < EW'(vl_q);
            m_nx[j]                  = bus.mask[j] && ((elem_idx + EW'(j)) < EW'(vl_q));
            res_nx[j*CNT_W +: CNT_W] = base + CNT_W'(pop);
            pop                      = pop + PW'(m_nx[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (vl == '0) ? FIN : RUN;
            end
            RUN: begin
                if (accept && beat_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (res_hs && bus.res_last) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q          <= '0;
            base          <= '0;
            elem_idx      <= '0;
            total         <= '0;
            bus.res       <= '0;
            bus.res_en    <= '0;
            bus.res_last  <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                vl_q     <= vl;
                base     <= '0;
                elem_idx <= '0;
                if (vl == '0) total <= '0;
            end
            if (accept) begin
                bus.res      <= res_nx;
                bus.res_en   <= en_nx;
                bus.res_last <= beat_last;
                base         <= base + CNT_W'(pop);
                elem_idx     <= elem_idx + EW'(LANES);
            end
            // A same-cycle accept refills the register, so valid stays high.
            if (accept)      bus.res_valid <= 1'b1;
            else if (res_hs) bus.res_valid <= 1'b0;
            if (state == DRAIN && res_hs && bus.res_last) total <= base;
        end
    end
endmodule
